// File: rtl/stream_spill_register.sv
// Two-entry registered valid/ready slice: data_o, valid_o and ready_o all come straight from flops.
// BYPASS=1 collapses the block to wires with no state.
module stream_spill_register #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (BYPASS) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_ni, clr_i};
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : g_spill
    // Encoding is {b_full, a_full}; BAD is never entered.
    typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      BAD   = 2'b10,
      FULL  = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  push, pop;

    assign valid_o = state_q[0];
    assign ready_o = ~state_q[1];
    assign data_o  = a_q;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      if (clr_i) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (push) begin
              state_d = ONE;
              a_d     = data_i;
            end
          end
          ONE: begin
            case ({push, pop})
              2'b11: a_d = data_i;
              2'b10: begin
                state_d = FULL;
                b_d     = data_i;
              end
              2'b01: state_d = EMPTY;
              default: ;
            endcase
          end
          FULL: begin
            if (pop) begin
              state_d = ONE;
              a_d     = b_q;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= EMPTY;
        a_q     <= '0;
        b_q     <= '0;
      end else begin
        state_q <= state_d;
        a_q     <= a_d;
        b_q     <= b_d;
      end
    end

    a_no_state_10 : assert property (@(posedge clk_i) disable iff (!rst_ni)
      state_q != BAD);
    a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !ready_o |=> $stable(b_q));
    a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !clr_i) |=> (valid_o && $stable(data_o)));
  end

endmodule
